snake_screen_ctrl: RTL and testbench

SNAKE_SCREEN_CTRL -- requirements
Module: snake_screen_ctrl

---
 rtl/snake_screen_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_snake_screen_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_screen_ctrl.sv
// snake_screen_ctrl: start/play/fail control for the snake game plus the
// final pixel compositor in front of the VGA driver.
//
// Ports:
//   clk         VGA pixel clock
//   rstn        asynchronous active-low reset
//   key_n       raw start/restart button (active-low, asynchronous to clk)
//   game_over   one-cycle pulse from game logic when the snake dies
//   pixel_xpos  current pixel column (0 outside the display area)
//   pixel_ypos  current pixel row (0 outside the display area)
//   pixel_game  playfield RGB565, valid 1 cycle after its coordinates
//   pixel_fail  fail-text RGB565, valid 1 cycle after its coordinates
//   pixel_data  composited RGB565, 2 cycles after its coordinates
//   game_rst    one-cycle restart pulse to game logic on entry to PLAY
//   game_run    high while in PLAY
//   state       control state: 0 START, 1 PLAY, 2 FAIL
module snake_screen_ctrl #(
  parameter int          H_DISP       = 640,
  parameter int          V_DISP       = 480,
  parameter int          DEB_CYCLES   = 500000,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] COLOR_BORDER = 16'h07E0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_n,
  input  logic        game_over,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [15:0] pixel_game,
  input  logic [15:0] pixel_fail,
  output logic [15:0] pixel_data,
  output logic        game_rst,
  output logic        game_run,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [10:0] H_END = 11'(H_DISP);
  localparam logic [10:0] V_END = 11'(V_DISP);
  localparam logic [10:0] H_BRD = 11'(H_DISP - 8);
  localparam logic [10:0] V_BRD = 11'(V_DISP - 8);

  // key synchronizer and debouncer
  logic             key_s1;
  logic             key_s2;
  logic             key_stable;
  logic             key_stable_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             key_press;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_s1       <= 1'b1;
      key_s2       <= 1'b1;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      deb_cnt      <= '0;
    end else begin
      key_s1       <= key_n;
      key_s2       <= key_s1;
      key_stable_d <= key_stable;
      if (key_s2 == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_stable <= key_s2;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // only the press edge (stable 1->0) matters; release is ignored
  assign key_press = key_stable_d & ~key_stable;

  // frame start: first cycle of a run of (0,0) coordinates
  logic at_origin;
  logic at_origin_d;
  logic frame_tick;

  assign at_origin  = (pixel_xpos == '0) && (pixel_ypos == '0);
  assign frame_tick = at_origin & ~at_origin_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      at_origin_d <= 1'b0;
    end else begin
      at_origin_d <= at_origin;
    end
  end

  // control FSM; game_over wins over a coincident key_press in PLAY
  state_t ctrl_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_state <= ST_START;
      game_rst   <= 1'b0;
      game_run   <= 1'b0;
    end else begin
      game_rst <= 1'b0;
      case (ctrl_state)
        ST_START: begin
          if (key_press) begin
            ctrl_state <= ST_PLAY;
            game_rst   <= 1'b1;
            game_run   <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (game_over) begin
            ctrl_state <= ST_FAIL;
            game_run   <= 1'b0;
          end
        end
        ST_FAIL: begin
          if (key_press) begin
            ctrl_state <= ST_PLAY;
            game_rst   <= 1'b1;
            game_run   <= 1'b1;
          end
        end
        default: begin
          ctrl_state <= ST_START;
          game_run   <= 1'b0;
        end
      endcase
    end
  end

  assign state = ctrl_state;

  // display state follows the control state only at frame boundaries
  state_t             disp_state;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_state <= ST_START;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      if (frame_tick) begin
        disp_state <= ctrl_state;
      end
      if (disp_state != ST_FAIL) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // coordinates delayed one cycle to line up with pixel_game/pixel_fail
  logic [10:0] xd;
  logic [10:0] yd;
  logic        in_border;
  logic [15:0] pix_next;

  always_comb begin
    in_border = (xd < 11'd8) || (xd >= H_BRD) || (yd < 11'd8) || (yd >= V_BRD);
    pix_next  = '0;
    if ((xd < H_END) && (yd < V_END)) begin
      case (disp_state)
        ST_START: pix_next = in_border ? COLOR_BORDER : 16'h0000;
        ST_PLAY:  pix_next = pixel_game;
        ST_FAIL:  pix_next = blink_on ? pixel_fail : 16'h0000;
        default:  pix_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xd         <= '0;
      yd         <= '0;
      pixel_data <= '0;
    end else begin
      xd         <= pixel_xpos;
      yd         <= pixel_ypos;
      pixel_data <= pix_next;
    end
  end

endmodule

// File: tb/tb_snake_screen_ctrl.sv
module tb_snake_screen_ctrl;

  localparam int          H   = 160;
  localparam int          V   = 120;
  localparam int          DEB = 4;
  localparam int          BLK = 2;
  localparam logic [15:0] CB  = 16'h07E0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        key_n;
  logic        game_over;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [15:0] pixel_game;
  logic [15:0] pixel_fail;
  logic [15:0] pixel_data;
  logic        game_rst;
  logic        game_run;
  logic [1:0]  state;

  snake_screen_ctrl #(
    .H_DISP(H), .V_DISP(V), .DEB_CYCLES(DEB), .BLINK_FRAMES(BLK), .COLOR_BORDER(CB)
  ) dut (
    .clk(clk), .rstn(rstn), .key_n(key_n), .game_over(game_over),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .pixel_game(pixel_game), .pixel_fail(pixel_fail),
    .pixel_data(pixel_data), .game_rst(game_rst), .game_run(game_run), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rst_pulses = 0;
  bit fail_const = 1'b0;

  // reference model
  bit          raw_q [2];
  bit          win [DEB];
  bit          m_stable;
  bit          m_press;
  int          m_state;
  bit          m_rst;
  bit          m_run;
  bit          m_prev_org;
  int          m_disp;
  int          m_fail_ticks;
  int          m_xd;
  int          m_yd;
  logic [15:0] m_pix;

  function automatic logic [15:0] gfn(input int x, input int y);
    return 16'((x * 7 + y * 131) ^ 32'hA5C3);
  endfunction

  function automatic logic [15:0] ffn(input int x, input int y);
    return 16'((x * 13 + y * 3) ^ 32'h5A3C);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q[0] = 1'b1;
    raw_q[1] = 1'b1;
    foreach (win[i]) win[i] = 1'b1;
    m_stable     = 1'b1;
    m_press      = 1'b0;
    m_state      = 0;
    m_rst        = 1'b0;
    m_run        = 1'b0;
    m_prev_org   = 1'b0;
    m_disp       = 0;
    m_fail_ticks = 0;
    m_xd         = 0;
    m_yd         = 0;
    m_pix        = '0;
  endtask

  // one clock edge of the intended behaviour
  task automatic model_edge();
    bit sync_now, all_diff, press, org, tk, new_stable;
    int st_old;
    if (!rstn) begin
      model_reset();
      return;
    end
    sync_now = raw_q[1];
    raw_q[1] = raw_q[0];
    raw_q[0] = key_n;
    for (int i = DEB - 1; i > 0; i--) win[i] = win[i-1];
    win[0] = sync_now;
    // a level is accepted once the last DEB synchronized samples all disagree
    all_diff = 1'b1;
    foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
    new_stable = all_diff ? sync_now : m_stable;
    press    = m_press;
    m_press  = m_stable && !new_stable;
    m_stable = new_stable;

    st_old = m_state;
    m_rst  = 1'b0;
    if (m_state == 0 && press) begin m_state = 1; m_rst = 1'b1; end
    else if (m_state == 1 && game_over) m_state = 2;
    else if (m_state == 2 && press) begin m_state = 1; m_rst = 1'b1; end
    m_run = (m_state == 1);

    org = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    tk  = org && !m_prev_org;
    m_prev_org = org;

    if (m_xd >= H || m_yd >= V) m_pix = 16'h0000;
    else if (m_disp == 0)
      m_pix = (m_xd < 8 || m_xd >= H - 8 || m_yd < 8 || m_yd >= V - 8) ? CB : 16'h0000;
    else if (m_disp == 1) m_pix = pixel_game;
    else m_pix = (((m_fail_ticks / BLK) % 2) == 0) ? pixel_fail : 16'h0000;

    if (m_disp != 2) m_fail_ticks = 0;
    else if (tk) m_fail_ticks++;
    if (tk) m_disp = st_old;
    m_xd = int'(pixel_xpos);
    m_yd = int'(pixel_ypos);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (game_rst === 1'b1) rst_pulses++;
    chk("state", 32'(state), 32'(m_state));
    chk("game_run", 32'(game_run), 32'(m_run));
    chk("game_rst", 32'(game_rst), 32'(m_rst));
    chk("pixel_data", 32'(pixel_data), 32'(m_pix));
  endtask

  // renderer outputs belong to the coordinates of the previous cycle
  task automatic drive(input int x, input int y);
    pixel_game = gfn(int'(pixel_xpos), int'(pixel_ypos));
    pixel_fail = fail_const ? 16'hFFFF : ffn(int'(pixel_xpos), int'(pixel_ypos));
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_run", 32'(game_run), 32'd0);
    chk("areset_rst", 32'(game_rst), 32'd0);
    chk("areset_pixel", 32'(pixel_data), 32'h0);
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [13];
  logic [15:0] blink_pat [6];

  initial begin
    bit found;
    int key_left;
    int x, y, len;

    tbl[0]  = '{0, 0, CB};
    tbl[1]  = '{100, 100, 16'h0000};
    tbl[2]  = '{7, 50, CB};
    tbl[3]  = '{8, 50, 16'h0000};
    tbl[4]  = '{152, 50, CB};
    tbl[5]  = '{151, 50, 16'h0000};
    tbl[6]  = '{50, 7, CB};
    tbl[7]  = '{50, 8, 16'h0000};
    tbl[8]  = '{50, 112, CB};
    tbl[9]  = '{50, 111, 16'h0000};
    tbl[10] = '{160, 5, 16'h0000};
    tbl[11] = '{5, 120, 16'h0000};
    tbl[12] = '{159, 119, CB};
    blink_pat[0] = 16'hFFFF; blink_pat[1] = 16'hFFFF; blink_pat[2] = 16'h0000;
    blink_pat[3] = 16'h0000; blink_pat[4] = 16'hFFFF; blink_pat[5] = 16'hFFFF;

    rstn = 1'b1; key_n = 1'b1; game_over = 1'b0;
    pixel_xpos = '0; pixel_ypos = '0; pixel_game = '0; pixel_fail = '0;
    model_reset();
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_run", 32'(game_run), 32'd0);
    chk("reset_rst", 32'(game_rst), 32'd0);
    chk("reset_pixel", 32'(pixel_data), 32'h0);
    rstn = 1'b1;

    // start screen table
    foreach (tbl[i]) begin
      drive(tbl[i].x, tbl[i].y); tick();
      drive(tbl[i].x, tbl[i].y); tick();
      chk($sformatf("start_tbl%0d", i), 32'(pixel_data), 32'(tbl[i].exp));
    end

    // 3-cycle glitch is rejected
    drive(50, 50);
    rst_pulses = 0;
    key_n = 1'b0;
    repeat (3) begin drive(50, 50); tick(); end
    key_n = 1'b1;
    repeat (15) begin drive(50, 50); tick(); end
    chk("glitch_state", 32'(state), 32'd0);
    chk("glitch_rst_pulses", 32'(rst_pulses), 32'd0);

    // 10-cycle press enters PLAY; display changes only at next frame
    rst_pulses = 0;
    key_n = 1'b0;
    repeat (10) begin drive(3, 3); tick(); end
    key_n = 1'b1;
    repeat (12) begin drive(3, 3); tick(); end
    chk("press_state", 32'(state), 32'd1);
    chk("press_run", 32'(game_run), 32'd1);
    chk("press_rst_pulses", 32'(rst_pulses), 32'd1);
    chk("press_border_kept", 32'(pixel_data), 32'(CB));
    drive(0, 0); tick();
    chk("tick_border_kept", 32'(pixel_data), 32'(CB));
    drive(50, 50); tick();
    chk("play_pix_origin", 32'(pixel_data), 32'(gfn(0, 0)));
    drive(50, 50); tick();
    chk("play_pix_latency", 32'(pixel_data), 32'(gfn(50, 50)));

    // game_over coincident with key_press: FAIL, press discarded
    rst_pulses = 0;
    key_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      drive(50, 50);
      if (m_press) begin
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        found = 1'b1;
      end else begin
        tick();
      end
    end
    chk("coincide_press_seen", 32'(found), 32'd1);
    chk("coincide_state", 32'(state), 32'd2);
    key_n = 1'b1;
    repeat (15) begin drive(50, 50); tick(); end
    chk("coincide_state_hold", 32'(state), 32'd2);
    chk("coincide_rst_pulses", 32'(rst_pulses), 32'd0);

    // blink over six frames
    fail_const = 1'b1;
    for (int f = 0; f < 6; f++) begin
      drive(0, 0); tick();
      repeat (4) begin drive(50, 50); tick(); end
      chk($sformatf("blink_frame%0d", f), 32'(pixel_data), 32'(blink_pat[f]));
    end

    // reset in FAIL mid-frame, then a new press is needed
    drive(50, 50); tick();
    async_reset();
    fail_const = 1'b0;
    drive(3, 60); tick();
    drive(3, 60); tick();
    chk("post_reset_border", 32'(pixel_data), 32'(CB));
    repeat (30) begin drive(3, 60); tick(); end
    chk("post_reset_idle", 32'(state), 32'd0);
    key_n = 1'b0;
    repeat (10) begin drive(3, 60); tick(); end
    key_n = 1'b1;
    repeat (10) begin drive(3, 60); tick(); end
    chk("post_reset_press", 32'(state), 32'd1);

    // random traffic against the model
    key_left = 0;
    for (int c = 0; c < 4000; ) begin
      len = $urandom_range(4, 40);
      for (int k = 0; k < len; k++) begin
        if (k == 0) drive(0, 0);
        else begin
          x = $urandom_range(0, H + 15);
          y = $urandom_range(0, V + 15);
          if (x == 0 && y == 0) x = 1;
          drive(x, y);
        end
        if (key_left == 0) begin
          key_n = 1'($urandom_range(0, 1));
          key_left = $urandom_range(1, 12);
        end
        key_left--;
        game_over = ($urandom_range(0, 40) == 0);
        tick();
        c++;
        if ($urandom_range(0, 1499) == 0) async_reset();
      end
    end
    game_over = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
